// File: rtl/ypc_pkg.sv
// Shared definitions for the ypc_multicycle core: FSM states, RV32I opcode
// and funct constants used by the decoder, and the default boot address.
package ypc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } ypc_state_e;

    localparam logic [63:0] YPC_RESET_PC = 64'h0000_0000_8000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    // Register x10 (a0) carries the program's exit code.
    localparam logic [4:0] REG_A0 = 5'd10;

    // A register index is legal only if it exists in this configuration
    // (RV-E cores have 16 registers).
    function automatic logic reg_ok(input logic [4:0] addr, input int nregs);
        return int'(addr) < nregs;
    endfunction

endpackage

// File: rtl/ypc_regfile.sv
// Integer register file: NREGS x XLEN, two asynchronous read ports and one
// synchronous write port. x0 always reads zero and ignores writes; indices
// beyond NREGS read as zero and are never written.
module ypc_regfile
    import ypc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];

    // Clear all registers on reset; otherwise accept one write per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0) && reg_ok(waddr, NREGS)) begin
            regs_q[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata1 = ((raddr1 != 5'd0) && reg_ok(raddr1, NREGS)) ? regs_q[raddr1[AW-1:0]] : '0;
    assign rdata2 = ((raddr2 != 5'd0) && reg_ok(raddr2, NREGS)) ? regs_q[raddr2[AW-1:0]] : '0;

endmodule

// File: rtl/ypc_multicycle.sv
// Minimal multi-cycle RV32I/RV64I subset core (ADDI, ADD, LUI, AUIPC, JAL,
// JALR, EBREAK). Each instruction walks FETCH -> WAIT -> EXEC; EBREAK parks
// the core in HALT with x10 on exit_code.
//
// Build option YPC_ILLEGAL_TRAP_EN: when defined, illegal instructions and
// jump targets with bit 1 set halt the core with exit_code all-ones and pc
// left on the faulting instruction. When undefined, illegal instructions
// retire as NOPs and misaligned targets are taken as-is.
//
// Fetch handshake: the request transfers in a cycle where imem_req_valid and
// imem_req_ready are both 1; imem_addr is held stable while valid waits for
// ready, and valid drops the cycle after the transfer. The response is a
// single-cycle imem_rsp_valid pulse with no back-pressure, honoured only in
// WAIT.
module ypc_multicycle
    import ypc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = YPC_RESET_PC[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            retire,
    output logic            halt,
    output logic [XLEN-1:0] exit_code,
    output ypc_state_e      dbg_state
);

`ifdef YPC_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    ypc_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            req_valid_q, req_valid_d;
    logic            retire_q, retire_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] exit_code_q, exit_code_d;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Immediates, sign-extended to XLEN through signed size casts
    logic signed [11:0] imm_i12;
    logic signed [31:0] imm_u32;
    logic signed [20:0] imm_j21;
    logic [XLEN-1:0]    imm_i, imm_u, imm_j;

    assign imm_i12 = ir_q[31:20];
    assign imm_u32 = {ir_q[31:12], 12'h000};
    assign imm_j21 = {ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_i   = XLEN'(imm_i12);
    assign imm_u   = XLEN'(imm_u32);
    assign imm_j   = XLEN'(imm_j21);

    // Register file; port 2 reads x10 for SYSTEM so EBREAK can report it
    logic [4:0]      raddr2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rf_we;
    logic [XLEN-1:0] wr_data;

    assign raddr2 = (opcode == OPC_SYSTEM) ? REG_A0 : rs2;

    ypc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wr_data),
        .raddr1 (rs1),
        .raddr2 (raddr2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Decode results
    logic            legal, is_ebreak, is_jump, wr_en;
    logic [XLEN-1:0] next_pc, pc_plus4, jalr_sum;
    logic            misaligned, do_trap;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = rs1_data + imm_i;

    // Decode the latched instruction into write-back and next-pc values.
    always_comb begin
        legal     = 1'b0;
        is_ebreak = 1'b0;
        is_jump   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        next_pc   = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                legal   = reg_ok(rd, NREGS);
                wr_en   = 1'b1;
                wr_data = imm_u;
            end
            OPC_AUIPC: begin
                legal   = reg_ok(rd, NREGS);
                wr_en   = 1'b1;
                wr_data = pc_q + imm_u;
            end
            OPC_JAL: begin
                legal   = reg_ok(rd, NREGS);
                is_jump = 1'b1;
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                next_pc = pc_q + imm_j;
            end
            OPC_JALR: begin
                legal   = (funct3 == F3_JALR) && reg_ok(rd, NREGS) && reg_ok(rs1, NREGS);
                is_jump = 1'b1;
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                next_pc = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OPC_OP_IMM: begin
                legal   = (funct3 == F3_ADD) && reg_ok(rd, NREGS) && reg_ok(rs1, NREGS);
                wr_en   = 1'b1;
                wr_data = rs1_data + imm_i;
            end
            OPC_OP: begin
                legal   = (funct3 == F3_ADD) && (funct7 == F7_ADD) && reg_ok(rd, NREGS)
                          && reg_ok(rs1, NREGS) && reg_ok(rs2, NREGS);
                wr_en   = 1'b1;
                wr_data = rs1_data + rs2_data;
            end
            OPC_SYSTEM: begin
                legal     = (ir_q == INSN_EBREAK);
                is_ebreak = legal;
            end
            default: ;
        endcase
    end

    assign misaligned = legal && is_jump && next_pc[1];
    assign do_trap    = TRAP_EN && (!legal || misaligned);

    // Next-state logic for the FETCH/WAIT/EXEC/HALT sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        req_valid_d = req_valid_q;
        retire_d    = 1'b0;
        halt_d      = halt_q;
        exit_code_d = exit_code_q;
        rf_we       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!req_valid_q) begin
                    req_valid_d = 1'b1;
                end else if (imem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retire_d = 1'b1;
                if (do_trap) begin
                    state_d     = ST_HALT;
                    halt_d      = 1'b1;
                    exit_code_d = '1;
                end else if (is_ebreak) begin
                    state_d     = ST_HALT;
                    halt_d      = 1'b1;
                    exit_code_d = rs2_data;
                end else begin
                    rf_we       = legal && wr_en;
                    pc_d        = legal ? next_pc : pc_plus4;
                    state_d     = ST_FETCH;
                    req_valid_d = 1'b1;
                end
            end
            ST_HALT: ;
            default: state_d = ST_HALT;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            req_valid_q <= 1'b0;
            retire_q    <= 1'b0;
            halt_q      <= 1'b0;
            exit_code_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            req_valid_q <= req_valid_d;
            retire_q    <= retire_d;
            halt_q      <= halt_d;
            exit_code_q <= exit_code_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign retire         = retire_q;
    assign halt           = halt_q;
    assign exit_code      = exit_code_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ypc_multicycle.sv
// Directed bench for ypc_multicycle: small programs are served from a local
// memory, expected fetch addresses are queued up front and popped as the
// core requests, and the halt/exit_code/retire outcome is checked per program.
module tb_ypc_multicycle;
    import ypc_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic             clk;
    logic             reset;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rdata;
    logic             retire;
    logic             halt;
    logic [XLEN-1:0]  exit_code;
    ypc_state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    int retire_cnt = 0;
    int retire_base = 0;

    logic [31:0] mem [64];
    logic [31:0] exp_q[$];

    ypc_multicycle #(
        .XLEN     (XLEN),
        .NREGS    (32),
        .RESET_PC (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .retire         (retire),
        .halt           (halt),
        .exit_code      (exit_code),
        .dbg_state      (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retire pulses are counted at the rising edge (pre-update value).
    always @(posedge clk) begin
        if (retire) retire_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Instruction encoders
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[11:0], rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int off);
        logic [31:0] o;
        o = off;
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[11:0], rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        if (idx < 64) return mem[idx[5:0]];
        return 32'h0010_0073;
    endfunction

    // Scoreboard comparison
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0010_0073;
        exp_q.delete();
    endtask

    // Driver: reset and check the reset state
    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'(BASE));
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_exit_code", 64'(exit_code), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_FETCH));
        reset = 1'b1;
        retire_base = retire_cnt;
    endtask

    // Driver: bounded wait for a fetch request
    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", 64'(imem_req_valid), 64'd1);
    endtask

    // Driver: serve one fetch with the given ready and response delays
    task automatic serve_one(input int rdy_dly, input int rsp_dly);
        logic [31:0] a;
        logic [31:0] e;
        a = imem_addr;
        if (exp_q.size() == 0) begin
            check("fetch_unexpected", 64'(exp_q.size()), 64'd1);
            e = 32'hxxxx_xxxx;
        end else begin
            e = exp_q.pop_front();
        end
        check("fetch_addr", 64'(a), 64'(e));
        for (int i = 0; i < rdy_dly; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            check("addr_stable", 64'(imem_addr), 64'(a));
            check("req_held", 64'(imem_req_valid), 64'd1);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("no_dup_req", 64'(imem_req_valid), 64'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            imem_rdata = $urandom;
            @(negedge clk);
            check("wait_no_req", 64'(imem_req_valid), 64'd0);
            check("wait_no_retire", 64'(retire), 64'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rdata     = mem_word(a);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rdata     = $urandom;
        @(negedge clk);
    endtask

    // Driver: serve fetches until the core halts, with small random delays
    task automatic run_prog();
        int n;
        int idle;
        bit done;
        n = 0;
        idle = 0;
        done = 1'b0;
        while (!done) begin
            if (halt) begin
                done = 1'b1;
            end else if (imem_req_valid) begin
                serve_one($urandom_range(0, 2), $urandom_range(0, 2));
                idle = 0;
                n++;
                if (n > 40) begin
                    check("instr_budget", 64'(n), 64'd40);
                    done = 1'b1;
                end
            end else begin
                idle++;
                if (idle > 20) begin
                    check("req_timeout", 64'(imem_req_valid), 64'd1);
                    done = 1'b1;
                end
                @(negedge clk);
            end
        end
    endtask

    // Checks after halt: outcome, then a frozen core despite stray responses
    task automatic after_halt(input logic [31:0] exp_exit, input int exp_retires, input logic [31:0] exp_pc);
        check("halt", 64'(halt), 64'd1);
        check("exit_code", 64'(exit_code), 64'(exp_exit));
        check("fetch_q_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rdata     = enc_addi(5'd10, 5'd0, 55);
            imem_req_ready = 1'b1;
            @(negedge clk);
            check("halt_no_req", 64'(imem_req_valid), 64'd0);
            check("halt_no_retire", 64'(retire), 64'd0);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        check("halt_sticky", 64'(halt), 64'd1);
        check("halt_state", 64'(dbg_state), 64'(ST_HALT));
        check("halt_pc", 64'(imem_addr), 64'(exp_pc));
        check("halt_exit_frozen", 64'(exit_code), 64'(exp_exit));
        check("retire_count", 64'(retire_cnt - retire_base), 64'(exp_retires));
    endtask

    // Directed sequence
    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;

        // ADDI chain then EBREAK with x10 still zero
        clear_mem();
        mem[0] = enc_addi(5'd1, 5'd0, 5);
        mem[1] = enc_addi(5'd1, 5'd1, -3);
        mem[2] = INSN_EBREAK;
        exp_q.push_back(BASE); exp_q.push_back(BASE + 4); exp_q.push_back(BASE + 8);
        do_reset();
        @(negedge clk);
        check("first_req", 64'(imem_req_valid), 64'd1);
        run_prog();
        after_halt(32'h0, 3, BASE + 8);

        // Same chain, x1 copied into x10 to expose its value
        clear_mem();
        mem[0] = enc_addi(5'd1, 5'd0, 5);
        mem[1] = enc_addi(5'd1, 5'd1, -3);
        mem[2] = enc_add(5'd10, 5'd1, 5'd0);
        mem[3] = INSN_EBREAK;
        for (int i = 0; i < 4; i++) exp_q.push_back(BASE + 32'(4 * i));
        do_reset();
        run_prog();
        after_halt(32'h2, 4, BASE + 12);

        // Wrap-around: -1 + -1
        clear_mem();
        mem[0] = enc_addi(5'd2, 5'd0, -1);
        mem[1] = enc_add(5'd10, 5'd2, 5'd2);
        mem[2] = INSN_EBREAK;
        for (int i = 0; i < 3; i++) exp_q.push_back(BASE + 32'(4 * i));
        do_reset();
        run_prog();
        after_halt(32'hFFFF_FFFE, 3, BASE + 8);

        // LUI
        clear_mem();
        mem[0] = enc_u(OPC_LUI, 5'd10, 20'h12345);
        mem[1] = INSN_EBREAK;
        exp_q.push_back(BASE); exp_q.push_back(BASE + 4);
        do_reset();
        run_prog();
        after_halt(32'h1234_5000, 2, BASE + 4);

        // Negative LUI plus ADDI -1 wraps to 0x7FFFFFFF
        clear_mem();
        mem[0] = enc_u(OPC_LUI, 5'd10, 20'h80000);
        mem[1] = enc_addi(5'd10, 5'd10, -1);
        mem[2] = INSN_EBREAK;
        for (int i = 0; i < 3; i++) exp_q.push_back(BASE + 32'(4 * i));
        do_reset();
        run_prog();
        after_halt(32'h7FFF_FFFF, 3, BASE + 8);

        // JAL forward, then JALR back through the link register
        clear_mem();
        mem[0] = enc_jal(5'd1, 8);
        mem[1] = INSN_EBREAK;
        mem[2] = enc_add(5'd10, 5'd1, 5'd0);
        mem[3] = enc_jalr(5'd0, 5'd1, 0);
        exp_q.push_back(BASE); exp_q.push_back(BASE + 8);
        exp_q.push_back(BASE + 12); exp_q.push_back(BASE + 4);
        do_reset();
        run_prog();
        after_halt(BASE + 4, 4, BASE + 4);

        // AUIPC, then JALR with rd==rs1 and an odd offset
        clear_mem();
        mem[0] = enc_u(OPC_AUIPC, 5'd5, 20'h00000);
        mem[1] = enc_jalr(5'd5, 5'd5, 13);
        mem[3] = enc_add(5'd10, 5'd5, 5'd0);
        mem[4] = INSN_EBREAK;
        exp_q.push_back(BASE); exp_q.push_back(BASE + 4);
        exp_q.push_back(BASE + 12); exp_q.push_back(BASE + 16);
        do_reset();
        run_prog();
        after_halt(BASE + 8, 4, BASE + 16);

        // Back-pressure: ready held low 5 cycles, response 3 cycles late
        clear_mem();
        mem[0] = enc_addi(5'd10, 5'd0, 7);
        mem[1] = INSN_EBREAK;
        exp_q.push_back(BASE); exp_q.push_back(BASE + 4);
        do_reset();
        wait_req();
        serve_one(5, 3);
        check("stall_one_retire", 64'(retire), 64'd1);
        run_prog();
        after_halt(32'h7, 2, BASE + 4);

        // Writes to x0 are dropped
        clear_mem();
        mem[0] = enc_addi(5'd0, 5'd0, 9);
        mem[1] = enc_add(5'd10, 5'd0, 5'd0);
        mem[2] = INSN_EBREAK;
        for (int i = 0; i < 3; i++) exp_q.push_back(BASE + 32'(4 * i));
        do_reset();
        run_prog();
        after_halt(32'h0, 3, BASE + 8);

        // Illegal opcode 0x0000000B
        clear_mem();
        mem[0] = enc_addi(5'd10, 5'd0, 1);
        mem[1] = 32'h0000_000B;
        mem[2] = enc_addi(5'd10, 5'd10, 1);
        mem[3] = INSN_EBREAK;
`ifdef YPC_ILLEGAL_TRAP_EN
        exp_q.push_back(BASE); exp_q.push_back(BASE + 4);
        do_reset();
        run_prog();
        after_halt(32'hFFFF_FFFF, 2, BASE + 4);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(BASE + 32'(4 * i));
        do_reset();
        run_prog();
        after_halt(32'h2, 4, BASE + 12);
`endif

        // Reset while waiting for a response; a late response is ignored
        clear_mem();
        mem[0] = enc_addi(5'd10, 5'd0, 3);
        mem[1] = INSN_EBREAK;
        do_reset();
        wait_req();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("mid_state_wait", 64'(dbg_state), 64'(ST_WAIT));
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_req", 64'(imem_req_valid), 64'd0);
        check("mid_rst_addr", 64'(imem_addr), 64'(BASE));
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = enc_addi(5'd10, 5'd0, 99);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("late_rsp_state", 64'(dbg_state), 64'(ST_FETCH));
        check("late_rsp_req", 64'(imem_req_valid), 64'd1);
        check("late_rsp_addr", 64'(imem_addr), 64'(BASE));
        retire_base = retire_cnt;
        exp_q.push_back(BASE); exp_q.push_back(BASE + 4);
        run_prog();
        after_halt(32'h3, 2, BASE + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ypc_multicycle.md
YPC_MULTICYCLE -- requirements
Module: ypc_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data/address width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32, giving the register count (16 for RV-E, 32 otherwise).
REQ-003 SHALL have parameter RESET_PC, default 32'h8000_0000 zero-extended to XLEN, giving the first fetch address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-007 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-008 SHALL have port imem_addr, output, XLEN bits: fetch address, equal to pc.
REQ-009 SHALL have port imem_rsp_valid, input, 1 bit: instruction word valid.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-011 SHALL have port retire, output, 1 bit: one-cycle pulse per committed instruction.
REQ-012 SHALL have port halt, output, 1 bit: core has stopped; sticky until reset.
REQ-013 SHALL have port exit_code, output, XLEN bits: value of x10 captured when halt rises.

Function
REQ-014 SHALL implement FSM FETCH -> WAIT -> EXEC -> FETCH, plus terminal HALT.
REQ-015 FETCH: SHALL assert imem_req_valid and hold imem_addr stable until imem_req_ready; the handshake cycle moves the FSM to WAIT.
REQ-016 WAIT: SHALL latch imem_rdata into the instruction register in the cycle imem_rsp_valid is 1, then move to EXEC; it SHALL wait indefinitely while imem_rsp_valid is 0.
REQ-017 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-018 EXEC: SHALL decode, write rd, update pc, pulse retire, and return to FETCH, all in one cycle; the minimum is 3 cycles per instruction.
REQ-019 SHALL support ADDI, ADD, LUI, AUIPC, JAL, JALR and EBREAK; immediates are sign-extended to XLEN; arithmetic wraps modulo 2^XLEN.
REQ-020 JAL/JALR SHALL write pc+4 to rd; the JALR target is (rs1+imm) with bit 0 cleared; a JALR with rd==rs1 SHALL use the old rs1 value.
REQ-021 Writes to x0 SHALL be discarded and x0 SHALL read as 0.
REQ-022 Register addresses >= NREGS SHALL be treated as illegal instructions.
REQ-023 EBREAK in EXEC SHALL move the FSM to HALT, set halt=1, capture exit_code=x10, and pulse retire, with pc unchanged.
REQ-024 HALT SHALL keep imem_req_valid=0, retire=0 and all architectural state frozen.
REQ-025 Illegal opcodes SHALL be handled per REQ-029/REQ-030.

Reset
REQ-026 On reset low, the core SHALL set pc=RESET_PC, FSM=FETCH, halt=0, retire=0, exit_code=0 and imem_req_valid=0, and clear all registers to 0.
REQ-027 Reset asserted mid-handshake SHALL abandon the transaction; after release the first request SHALL be to RESET_PC, and any late imem_rsp_valid SHALL be ignored (FSM not in WAIT).
REQ-028 imem_req_valid SHALL first assert in the cycle after reset deassertion.

Configuration
REQ-029 With YPC_ILLEGAL_TRAP_EN defined, an illegal instruction or a jump target with bit 1 set SHALL halt as EBREAK does, but with exit_code = all-ones and pc held at the faulting instruction.
REQ-030 Without YPC_ILLEGAL_TRAP_EN, an illegal instruction SHALL retire as a NOP (pc+4, no register write), and a misaligned target SHALL be taken as-is.

Structure
REQ-031 Package ypc_pkg SHALL hold the FSM state enum, opcode/funct constants, and the default RESET_PC.
REQ-032 Sub-module ypc_regfile (NREGS x XLEN, 2 read ports, 1 write port, x0 hardwired) SHALL be instantiated once; decode and FSM stay in the top.

Verification
REQ-033 ADDI x1,x0,5; ADDI x1,x1,-3; EBREAK with x10=0 -> x1=2; 3 retire pulses; halt=1; exit_code=0.
REQ-034 LUI x10,0x12345; EBREAK -> exit_code=0x12345000; with XLEN=64, a negative LUI (0x80000) sign-extends to 0xFFFFFFFF80000000.
REQ-035 JAL x1,+8 at 0x80000000 -> x1=0x80000004; next fetch at 0x80000008; JALR x0,0(x1) -> fetch at 0x80000004.
REQ-036 imem_req_ready held low 5 cycles and imem_rsp_valid delayed 3 cycles -> imem_addr stable throughout; a single retire; no duplicate request.
REQ-037 Reset low in WAIT, rsp_valid pulsed after release -> pulse ignored; first request addr=RESET_PC.
REQ-038 Opcode 0x0000000B -> with YPC_ILLEGAL_TRAP_EN: halt=1 and exit_code=0xFFFFFFFF; without it: pc advances by 4 and no register changes.
